// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer bundle.
// The execute stage is the master; the sequencer is the slave and owns HI/LO.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            startE;
  logic [1:0]      opE;
  logic [XLEN-1:0] srcaE;
  logic [XLEN-1:0] srcbE;
  logic            hienE;
  logic            loenE;
  logic [XLEN-1:0] wdataE;
  logic [XLEN-1:0] hiout;
  logic [XLEN-1:0] loout;
  logic            busy;
  logic            stallMD;

  modport master (
    output startE, opE, srcaE, srcbE, hienE, loenE, wdataE,
    input  hiout, loout, busy, stallMD
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, hienE, loenE, wdataE,
    output hiout, loout, busy, stallMD
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle, on
// unsigned magnitudes; signs are applied in a final FIXUP cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiplies written at the
// start edge; divides keep the iterative path).
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   dvd_q, dvd_d;     // dividend as given, for divide-by-zero HI
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              dvz_q, dvz_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              busy;
  logic              go_iter;
  logic              sgn, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;

  // Operand magnitudes and sign flags for the op presented this cycle.
  always_comb begin
    sgn   = ~bus.opE[0];
    sa    = sgn & bus.srcaE[XLEN-1];
    sb    = sgn & bus.srcbE[XLEN-1];
    mag_a = sa ? (~bus.srcaE + 1'b1) : bus.srcaE;
    mag_b = sb ? (~bus.srcbE + 1'b1) : bus.srcbE;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;

  // Sign-extended operands multiplied modulo 2^(2*XLEN) give the correct signed or
  // unsigned full product.
  always_comb begin
    fast_prod = {{XLEN{sa}}, bus.srcaE} * {{XLEN{sb}}, bus.srcbE};
    go_iter   = bus.startE & bus.opE[1];
  end
`else
  // Every op takes the iterative path.
  always_comb begin
    go_iter = bus.startE;
  end
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  // One radix-2 iteration of each datapath.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Partial remainder is always below the divisor, so XLEN+1 bits hold the shift.
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (div_diff[XLEN]) begin
      div_next = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  // Sign correction of the magnitude result. The -2^(XLEN-1) / -1 case needs no
  // special handling: magnitude quotient 2^(XLEN-1), positive, remainder 0.
  always_comb begin
    prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_lo_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_hi_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
  end

  // Next-state, iteration and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    dvd_d    = dvd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dvz_d    = dvz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.hienE) hi_d = bus.wdataE;
        if (bus.loenE) lo_d = bus.wdataE;
`ifdef MULDIV_FAST_MUL_EN
        if (bus.startE && !bus.opE[1]) begin
          hi_d = fast_prod[2*XLEN-1:XLEN];
          lo_d = fast_prod[XLEN-1:0];
        end
`endif
        if (go_iter) begin
          is_div_d = bus.opE[1];
          neg_lo_d = sa ^ sb;
          neg_hi_d = bus.opE[1] ? sa : (sa ^ sb);
          dvz_d    = (bus.srcbE == '0);
          dvd_d    = bus.srcaE;
          if (bus.opE[1]) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
          cnt_d   = CW'(XLEN - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else if (dvz_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dvz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      dvd_q    <= dvd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dvz_q    <= dvz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Outputs: busy decodes the state register only; stall also covers the start cycle.
  always_comb begin
    busy        = (state_q != StIdle);
    bus.busy    = busy;
    bus.stallMD = busy | bus.startE;
    bus.hiout   = hi_q;
    bus.loout   = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed test-plan steps plus random ops
// checked against a 64-bit arithmetic reference model.
// Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_sequencer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER_LAT = XLEN + 1;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {HI, LO} from plain 64-bit arithmetic (SV / and % truncate toward zero).
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      2'b00: begin q = sa * sb; res = q; end
      2'b01: begin uq = ua * ub; res = uq; end
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles, bounded so a stuck DUT still reaches the summary.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] m;
    int          cyc;
    int          exp_lat;
    m = model(op, a, b);
    exp_lat = (FastMul && !op[1]) ? 0 : ITER_LAT;
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    #1;
    chk({tag, " stall_start"}, {31'b0, bus.stallMD}, 32'd1);
    tick();
    bus.startE = 1'b0;
    bus.srcaE  = $urandom;
    bus.srcbE  = $urandom;
    chk({tag, " stall_after"}, {31'b0, bus.stallMD}, {31'b0, exp_lat != 0});
    wait_idle(cyc);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " hi"}, bus.hiout, m[63:32]);
    chk({tag, " lo"}, bus.loout, m[31:0]);
  endtask

  initial begin
    int          cyc;
    logic [1:0]  op;
    logic [31:0] a, b;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    bus.startE = 1'b0;
    bus.opE    = 2'b00;
    bus.srcaE  = '0;
    bus.srcbE  = '0;
    bus.hienE  = 1'b0;
    bus.loenE  = 1'b0;
    bus.wdataE = '0;
    tick();
    tick();
    chk("reset hi", bus.hiout, 32'd0);
    chk("reset lo", bus.loout, 32'd0);
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset stall", {31'b0, bus.stallMD}, 32'd0);
    reset = 1'b0;
    tick();

    do_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3);
    chk("mult hi const", bus.hiout, 32'hFFFF_FFFF);
    chk("mult lo const", bus.loout, 32'hFFFF_FFFA);
    do_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3);
    chk("multu hi const", bus.hiout, 32'h0000_0002);
    chk("multu lo const", bus.loout, 32'hFFFF_FFFA);
    do_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div lo const", bus.loout, 32'hFFFF_FFFD);
    chk("div hi const", bus.hiout, 32'hFFFF_FFFF);
    do_op("divu", 2'b11, 32'd100, 32'd7);
    chk("divu lo const", bus.loout, 32'd14);
    chk("divu hi const", bus.hiout, 32'd2);
    do_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf lo const", bus.loout, 32'h8000_0000);
    chk("ovf hi const", bus.hiout, 32'd0);
    do_op("divu by0", 2'b11, 32'd5, 32'd0);
    chk("by0 hi const", bus.hiout, 32'd5);
    chk("by0 lo const", bus.loout, 32'hFFFF_FFFF);

    // mthi / mtlo in IDLE: visible next cycle, not in the writing cycle.
    bus.hienE  = 1'b1;
    bus.wdataE = 32'h0000_1234;
    #1;
    chk("mthi no bypass", bus.hiout, 32'd5);
    tick();
    bus.hienE = 1'b0;
    chk("mthi", bus.hiout, 32'h0000_1234);
    bus.loenE  = 1'b1;
    bus.wdataE = 32'h0000_ABCD;
    tick();
    bus.loenE = 1'b0;
    chk("mtlo", bus.loout, 32'h0000_ABCD);

    // mtlo during RUN is ignored.
    bus.startE = 1'b1;
    bus.opE    = 2'b11;
    bus.srcaE  = 32'd1000;
    bus.srcbE  = 32'd10;
    tick();
    bus.startE = 1'b0;
    bus.loenE  = 1'b1;
    bus.hienE  = 1'b1;
    bus.wdataE = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) tick();
    chk("mtlo in run lo", bus.loout, 32'h0000_ABCD);
    chk("mthi in run hi", bus.hiout, 32'h0000_1234);
    wait_idle(cyc);
    bus.loenE = 1'b0;
    bus.hienE = 1'b0;
    chk("run ignore latency", cyc, ITER_LAT - 5);
    chk("run ignore lo", bus.loout, 32'd100);
    chk("run ignore hi", bus.hiout, 32'd0);

    // mthi together with a start: applied at the start edge, overwritten by FIXUP.
    bus.startE = 1'b1;
    bus.opE    = 2'b11;
    bus.srcaE  = 32'd9;
    bus.srcbE  = 32'd2;
    bus.hienE  = 1'b1;
    bus.wdataE = 32'h5555_5555;
    tick();
    bus.startE = 1'b0;
    bus.hienE  = 1'b0;
    chk("mthi with start", bus.hiout, 32'h5555_5555);
    wait_idle(cyc);
    chk("mthi with start hi", bus.hiout, 32'd1);
    chk("mthi with start lo", bus.loout, 32'd4);

    // Reset in RUN cycle 10 aborts; a following divu completes normally.
    bus.startE = 1'b1;
    bus.opE    = 2'b10;
    bus.srcaE  = 32'd12345;
    bus.srcbE  = 32'd67;
    tick();
    bus.startE = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre-reset busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'b0, bus.busy}, 32'd0);
    chk("abort hi", bus.hiout, 32'd0);
    chk("abort lo", bus.loout, 32'd0);
    do_op("divu after abort", 2'b11, 32'd77, 32'd5);

    // Single-cycle multiply in the fast build; divide always iterative.
    do_op("mult 6x7", 2'b00, 32'd6, 32'd7);
    chk("mult 6x7 lo const", bus.loout, 32'd42);
    do_op("div 42/6", 2'b10, 32'd42, 32'd6);
    chk("div 42/6 lo const", bus.loout, 32'd7);

    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op($sformatf("rand%0d op%0d", n, op), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
